// File: rtl/mm_result_collector.sv
// Result collector: rescales and saturates accumulator results, tags each with
// its row index and end-of-vector flag, and buffers them in a first-word-fallthrough FIFO.
module mm_result_collector #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int VEC_LEN = 8,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ACC_W-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(VEC_LEN)-1:0] out_idx,
  output logic                       out_last,
  output logic                       out_sat,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                vec_done_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(VEC_LEN);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  // Saturation bounds sign-extended to the accumulator width so the compare is exact.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             sat;
  } entry_t;

  entry_t                   mem [DEPTH];
  entry_t                   wr_entry;
  entry_t                   head;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level_q;
  logic [IDX_W-1:0]         row_cnt;
  logic [15:0]              vec_done_q;
  logic signed [ACC_W-1:0]  shifted;
  logic                     push;
  logic                     pop;

  // Handshake flags depend only on registered occupancy, never on out_ready.
  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shifted       = $signed(in_data) >>> SHIFT;
    wr_entry.data = shifted[OUT_W-1:0];
    wr_entry.sat  = 1'b0;
    wr_entry.idx  = row_cnt;
    wr_entry.last = (row_cnt == LAST_IDX);
    if (shifted > SAT_MAX) begin
      wr_entry.data = SAT_MAX[OUT_W-1:0];
      wr_entry.sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      wr_entry.data = SAT_MIN[OUT_W-1:0];
      wr_entry.sat  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      row_cnt    <= '0;
      vec_done_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      row_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head.last) vec_done_q <= vec_done_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by level_q and outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head         = mem[rd_ptr];
  assign out_data     = out_valid ? head.data : '0;
  assign out_idx      = out_valid ? head.idx  : '0;
  assign out_last     = out_valid && head.last;
  assign out_sat      = out_valid && head.sat;
  assign level        = level_q;
  assign vec_done_cnt = vec_done_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed testbench for mm_result_collector: default instance plus a SHIFT=4 instance
// for the saturation vectors. Inputs change on the falling edge, outputs are read there too.
module tb_mm_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_sat;
  logic [3:0]  level;
  logic [15:0] vec_done_cnt;

  logic        flush_s = 1'b0;
  logic        in_valid_s = 1'b0;
  logic        in_ready_s;
  logic [31:0] in_data_s = '0;
  logic        out_valid_s;
  logic        out_ready_s = 1'b0;
  logic [15:0] out_data_s;
  logic [2:0]  out_idx_s;
  logic        out_last_s;
  logic        out_sat_s;
  logic [3:0]  level_s;
  logic [15:0] vec_done_cnt_s;

  int tests = 0;
  int failures = 0;

  logic [31:0] sat_in  [3] = '{32'h0000_0123, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [15:0] sat_exp [3] = '{16'h0012, 16'h7FFF, 16'h8000};
  logic        sat_flg [3] = '{1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  mm_result_collector dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
    .level(level), .vec_done_cnt(vec_done_cnt)
  );

  mm_result_collector #(.SHIFT(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .out_idx(out_idx_s), .out_last(out_last_s), .out_sat(out_sat_s),
    .level(level_s), .vec_done_cnt(vec_done_cnt_s)
  );

  // Protocol watchdog: the FIFO must never accept when full or release when empty.
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready && level == 4'd8) begin
        failures++; $display("FAIL overflow_push: level %0d, required below 8", level);
      end
      if (out_valid && out_ready && level == 4'd0) begin
        failures++; $display("FAIL underflow_pop: level %0d, required above 0", level);
      end
    end
  end

  task automatic test_reset();
    #1;
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    tests++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    tests++; if ({out_last, out_sat} !== 2'b00) begin failures++; $display("FAIL reset_last_sat: got %b want 00", {out_last, out_sat}); end
    tests++; if (vec_done_cnt !== 16'd0) begin failures++; $display("FAIL reset_vec_done: got %0d want 0", vec_done_cnt); end
    tests++; if (out_valid_s !== 1'b0) begin failures++; $display("FAIL reset_out_valid_s: got %b want 0", out_valid_s); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n_in = 0;
    int n_out = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        tests++; if (out_data !== 16'(n_out + 1)) begin failures++; $display("FAIL basic_data: got %0d want %0d", out_data, n_out + 1); end
        tests++; if (out_idx !== 3'(n_out)) begin failures++; $display("FAIL basic_idx: got %0d want %0d", out_idx, n_out); end
        tests++; if (out_last !== (n_out == 7)) begin failures++; $display("FAIL basic_last: got %b at word %0d", out_last, n_out); end
        tests++; if (out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat: got %b want 0", out_sat); end
        n_out++;
      end
      in_valid = (n_in < 8);
      in_data  = 32'(n_in + 1);
      if (in_valid && in_ready) n_in++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (n_out != 8) begin failures++; $display("FAIL basic_count: got %0d words want 8", n_out); end
    tests++; if (vec_done_cnt !== 16'd1) begin failures++; $display("FAIL basic_vec_done: got %0d want 1", vec_done_cnt); end
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL basic_level: got %0d want 0", level); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_s = 1'b1;
      in_data_s  = sat_in[i];
    end
    @(negedge clk);
    in_valid_s = 1'b0;
    tests++; if (level_s !== 4'd3) begin failures++; $display("FAIL sat_level: got %0d want 3", level_s); end
    out_ready_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (out_data_s !== sat_exp[i]) begin failures++; $display("FAIL sat_data%0d: got %h want %h", i, out_data_s, sat_exp[i]); end
      tests++; if (out_sat_s !== sat_flg[i]) begin failures++; $display("FAIL sat_flag%0d: got %b want %b", i, out_sat_s, sat_flg[i]); end
      tests++; if (out_idx_s !== 3'(i)) begin failures++; $display("FAIL sat_idx%0d: got %0d want %0d", i, out_idx_s, i); end
    end
    @(negedge clk);
    out_ready_s = 1'b0;
    tests++; if (level_s !== 4'd0) begin failures++; $display("FAIL sat_drain: got %0d want 0", level_s); end
  endtask

  task automatic test_full_stall();
    int n_in = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(100 + n_in);
      if (in_ready) n_in++;
    end
    @(negedge clk);
    tests++; if (n_in != 8) begin failures++; $display("FAIL stall_accepts: got %0d want 8", n_in); end
    tests++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_full: got %b want 0", in_ready); end
    tests++; if (level !== 4'd8) begin failures++; $display("FAIL stall_level_full: got %0d want 8", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (level !== 4'd7) begin failures++; $display("FAIL stall_single_pop: got %0d want 7", level); end
    tests++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready_rise: got %b want 1", in_ready); end
    tests++; if (out_data !== 16'd101) begin failures++; $display("FAIL stall_head: got %0d want 101", out_data); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (level !== 4'd8) begin failures++; $display("FAIL stall_ninth_accept: got %0d want 8", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (out_data !== 16'(101 + i)) begin failures++; $display("FAIL stall_order: got %0d want %0d", out_data, 101 + i); end
      tests++; if (out_idx !== 3'((1 + i) % 8)) begin failures++; $display("FAIL stall_idx: got %0d want %0d", out_idx, (1 + i) % 8); end
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL stall_drain: got %0d want 0", level); end
    tests++; if (vec_done_cnt !== 16'd2) begin failures++; $display("FAIL stall_vec_done: got %0d want 2", vec_done_cnt); end
  endtask

  task automatic test_back_to_back();
    int lasts = 0;
    logic [2:0] e_idx;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(200 + i);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      e_idx = 3'((1 + k) % 8);
      tests++; if (level !== 4'd3) begin failures++; $display("FAIL b2b_level: got %0d want 3 at cycle %0d", level, k); end
      tests++; if (out_data !== 16'(200 + k)) begin failures++; $display("FAIL b2b_data: got %0d want %0d", out_data, 200 + k); end
      tests++; if (out_idx !== e_idx) begin failures++; $display("FAIL b2b_idx: got %0d want %0d", out_idx, e_idx); end
      tests++; if (out_last !== (e_idx == 3'd7)) begin failures++; $display("FAIL b2b_last: got %b at idx %0d", out_last, e_idx); end
      if (out_last) lasts++;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'(203 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (out_data !== 16'(220 + i)) begin failures++; $display("FAIL b2b_tail: got %0d want %0d", out_data, 220 + i); end
      tests++; if (out_idx !== 3'(5 + i)) begin failures++; $display("FAIL b2b_tail_idx: got %0d want %0d", out_idx, 5 + i); end
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (lasts != 2) begin failures++; $display("FAIL b2b_last_pulses: got %0d want 2", lasts); end
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL b2b_drain: got %0d want 0", level); end
    tests++; if (vec_done_cnt !== 16'd5) begin failures++; $display("FAIL b2b_vec_done: got %0d want 5", vec_done_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(300 + i);
    end
    @(negedge clk);
    flush   = 1'b1;
    in_data = 32'd305;
    @(negedge clk);
    flush   = 1'b0;
    in_data = 32'd306;
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL flush_level: got %0d want 0", level); end
    tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    tests++; if (vec_done_cnt !== 16'd5) begin failures++; $display("FAIL flush_vec_done: got %0d want 5", vec_done_cnt); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (level !== 4'd1) begin failures++; $display("FAIL flush_repush_level: got %0d want 1", level); end
    tests++; if (out_data !== 16'd306) begin failures++; $display("FAIL flush_repush_data: got %0d want 306", out_data); end
    tests++; if (out_idx !== 3'd0) begin failures++; $display("FAIL flush_repush_idx: got %0d want 0", out_idx); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(310 + i);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if ({out_idx, out_last} !== {3'd7, 1'b1}) begin failures++; $display("FAIL flush_head_last: got idx %0d last %b want 7/1", out_idx, out_last); end
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    tests++; if (vec_done_cnt !== 16'd5) begin failures++; $display("FAIL flush_pop_vec_done: got %0d want 5", vec_done_cnt); end
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL flush_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(400 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (level !== 4'd4) begin failures++; $display("FAIL areset_pre_level: got %0d want 4", level); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    tests++; if (level !== 4'd0) begin failures++; $display("FAIL areset_level: got %0d want 0", level); end
    tests++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    tests++; if (vec_done_cnt !== 16'd0) begin failures++; $display("FAIL areset_vec_done: got %0d want 0", vec_done_cnt); end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd500;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_idx !== 3'd0) begin failures++; $display("FAIL areset_first_idx: got %0d want 0", out_idx); end
    tests++; if (out_data !== 16'd500) begin failures++; $display("FAIL areset_first_data: got %0d want 500", out_data); end
    tests++; if (level !== 4'd1) begin failures++; $display("FAIL areset_first_level: got %0d want 1", level); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_full_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mm_result_collector.md
Name: mm_result_collector

Overview:
- Downstream stage of the matrix-multiplier control/datapath.
- Accepts the stream of signed accumulator results, one per output row, 8 per matrix-vector product, over a valid/ready handshake.
- Rescales and saturates each result to the output width, tags it with its row index and an end-of-vector marker, and buffers it in a small first-word-fallthrough FIFO.
- The buffer decouples the multiplier from a slow consumer, so the multiplier's `output_ready` stall path is rarely exercised.

Parameters:
- ACC_W, 32, width of signed accumulator results from the datapath.
- OUT_W, 16, width of signed output results.
- SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-OUT_W).
- VEC_LEN, 8, results per vector (row-index wrap point).
- DEPTH, 8, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of FIFO and row counter.
- in_valid  in  1  upstream result valid (multiplier `output_valid`).
- in_ready  out  1  collector can accept (drives multiplier `output_ready`).
- in_data  in  ACC_W  signed accumulator result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  OUT_W  signed scaled/saturated result.
- out_idx  out  $clog2(VEC_LEN)  row index of head entry.
- out_last  out  1  head entry is row VEC_LEN-1.
- out_sat  out  1  head entry was saturated.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- vec_done_cnt  out  16  count of vectors fully drained (entry with last popped); wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; level=0; row counter=0; vec_done_cnt=0.
  - in_ready=1, out_valid=0.
  - out_data, out_idx, out_last and out_sat read 0 while empty.
- Handshake:
  - Push on the cycle in_valid&&in_ready.
  - Pop on the cycle out_valid&&out_ready.
  - in_ready = (level != DEPTH), registered-state only; no combinational path from out_ready to in_ready.
  - out_valid = (level != 0).
  - Outputs come from the head register array (FWFT).
- Latency: a word pushed into an empty FIFO at edge N presents out_valid=1 in the cycle after edge N. No same-cycle bypass.
- Conversion, applied at push:
  - s = in_data >>> SHIFT (arithmetic shift, truncation toward -inf).
  - If s > 2^(OUT_W-1)-1: store max, sat=1.
  - If s < -2^(OUT_W-1): store min, sat=1.
  - Otherwise store s[OUT_W-1:0], sat=0.
- Tagging:
  - Row counter increments on each push.
  - The stored idx is the counter value at push.
  - last = (idx == VEC_LEN-1).
  - The counter wraps to 0 after VEC_LEN-1.
- Simultaneous push and pop:
  - Allowed when 0 < level < DEPTH; level unchanged.
  - When full, in_ready=0, so only the pop occurs. in_ready rises the next cycle.
  - When empty, only the push occurs.
- vec_done_cnt increments by 1 on each pop whose entry has last=1.
- flush=1:
  - Next edge: level=0, pointers=0, row counter=0.
  - Any push in the same cycle is discarded.
  - A pop in the same cycle does not increment vec_done_cnt.
  - vec_done_cnt itself is retained.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap naturally. The level counter resolves full versus empty.
- No overflow or underflow is possible by construction. Bench asserts: no push while level==DEPTH; no pop while level==0.

Test Plan:
- Reset, then push 8 results 1..8 with out_ready=1 -> out_data 1..8, out_idx 0..7, out_last only on idx 7, vec_done_cnt=1, level returns 0.
- SHIFT=4, push 0x00000123, 0x7FFFFFFF, 0x80000000 -> out_data 0x0012/sat=0, 0x7FFF/sat=1, 0x8000/sat=1.
- out_ready=0, push 10 words with in_valid held -> in_ready drops after the 8th accept, level=8. Raise out_ready for one cycle -> one pop, in_ready=1 next cycle, 9th word accepted, order preserved.
- Continuous in_valid and out_ready at level 3 for 20 cycles -> level stays 3, one word per cycle each side, idx wraps 7->0 with out_last pulses every 8 outputs.
- Push 5 words, assert flush with in_valid=1 -> level=0 next cycle, flushed-cycle word lost. Next push carries out_idx=0; vec_done_cnt unchanged.
- Assert rst asynchronously mid-stream (between edges, level=4) -> out_valid=0 and level=0 immediately, in_ready=1. After release, the first push has out_idx=0.
